sdp_ram_bw: RTL and testbench

- Parametrised single-clock simple dual-port RAM: one write port (A) and one read port (B).
- Adds per-byte write enables, a selectable read latency, a selectable read-during-write policy, a read-valid strobe and an optional post-reset clear sweep.
- Used as the generic inferred-memory building block under MemCompose-generated wrappers.

---
 rtl/sdp_ram_bw_if.sv | 28 ++
 rtl/sdp_ram_bw.sv | 141 ++++++++++++++
 tb/tb_sdp_ram_bw.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdp_ram_bw_if.sv
// Port bundle for sdp_ram_bw: write port A, read port B, read result and sweep status.
// The master drives requests; the slave (the RAM) returns read data and init_busy.
interface sdp_ram_bw_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) ();
    localparam int NB = DATA_W / 8;

    logic              ena;
    logic [NB-1:0]     wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dia;
    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dob;
    logic              dob_valid;
    logic              init_busy;

    modport master (
        output ena, wea, addra, dia, enb, addrb,
        input  dob, dob_valid, init_busy
    );

    modport slave (
        input  ena, wea, addra, dia, enb, addrb,
        output dob, dob_valid, init_busy
    );
endinterface

// File: rtl/sdp_ram_bw.sv
// Single-clock simple dual-port RAM with byte enables, 1/2-cycle read latency,
// selectable read-during-write policy and an optional post-reset clear sweep.
//
// state | meaning
// CLEAR | sweeping INIT_VALUE into every word; port requests ignored
// RUN   | normal read/write traffic
module sdp_ram_bw #(
    parameter int                DATA_W         = 16,
    parameter int                DEPTH          = 1024,
    parameter int                ADDR_W         = $clog2(DEPTH),
    parameter int                NB             = DATA_W / 8,
    parameter int                READ_LATENCY   = 1,
    parameter int                RDW_MODE       = 0,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE     = '0
) (
    input logic         clk,
    input logic         rst_n,
    sdp_ram_bw_if.slave bus
);

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              sweep_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_en;
    logic              rd_req;
    logic [DATA_W-1:0] rd_word;
    logic              stage_valid;
    logic [DATA_W-1:0] stage_data;
    logic [DATA_W-1:0] dob_q;
    logic              dob_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET) state_q <= ST_CLEAR;
            else                state_q <= ST_RUN;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                sweep_we = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    assign run         = (state_q == ST_RUN);
    assign wr_in_range = ({1'b0, bus.addra} < DEPTH_L);
    assign rd_in_range = ({1'b0, bus.addrb} < DEPTH_L);
    assign wr_en       = run & bus.ena & wr_in_range;
    assign rd_req      = run & bus.enb;

    // Array has no reset; only the sweep initialises it.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[cnt_q] <= INIT_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wea[i]) mem[bus.addra][8*i +: 8] <= bus.dia[8*i +: 8];
            end
        end
    end

    // Array read sees pre-edge contents (old data); write-first overlays the written lanes.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[bus.addrb];
            if (RDW_MODE == 1 && wr_en && bus.addra == bus.addrb) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.wea[i]) rd_word[8*i +: 8] = bus.dia[8*i +: 8];
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic              s1_valid_q;
        logic [DATA_W-1:0] s1_data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_req;
                if (rd_req) s1_data_q <= rd_word;
            end
        end

        assign stage_valid = s1_valid_q;
        assign stage_data  = s1_data_q;
    end else begin : g_lat1
        assign stage_valid = rd_req;
        assign stage_data  = rd_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dob_q       <= '0;
            dob_valid_q <= 1'b0;
        end else begin
            dob_valid_q <= stage_valid;
            if (stage_valid) dob_q <= stage_data;
        end
    end

    assign bus.dob       = dob_q;
    assign bus.dob_valid = dob_valid_q;
    assign bus.init_busy = ~run;

endmodule

// File: tb/tb_sdp_ram_bw.sv
// Scoreboard bench: two RAMs (latency 1 / old-data, latency 2 / write-first) share
// one stimulus stream; a word-array reference model predicts every read result.
module tb_sdp_ram_bw;

    localparam int          DW   = 16;
    localparam int          DEP  = 1000;
    localparam int          AW   = 10;
    localparam logic [15:0] INIT = 16'hA5A5;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   busy_left = 0;

    logic [15:0] mdl [DEP];
    logic [15:0] last0, last1;
    exp_t        q0[$];
    exp_t        q1[$];

    sdp_ram_bw_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    sdp_ram_bw_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    sdp_ram_bw #(
        .DATA_W(DW), .DEPTH(DEP), .READ_LATENCY(1), .RDW_MODE(0),
        .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );

    sdp_ram_bw #(
        .DATA_W(DW), .DEPTH(DEP), .READ_LATENCY(2), .RDW_MODE(1),
        .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail(input string nm, input int k);
        n_chk++;
        $display("FAIL %s on dut%0d at cycle %0d", nm, k, cyc);
    endtask

    // Monitor: pops the expected result whenever a read completes.
    task automatic mon(input int k, input logic v, input logic [15:0] d);
        exp_t e;
        int   sz;
        sz = (k == 0) ? q0.size() : q1.size();
        if (v) begin
            if (sz == 0) begin
                fail("unexpected_dob_valid", k);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("dob%0d", k), 32'(d), 32'(e.data));
                chk($sformatf("latency%0d", k), 32'(cyc), 32'(e.cyc));
                if (k == 0) last0 = e.data;
                else        last1 = e.data;
            end
        end else begin
            chk($sformatf("dob_hold%0d", k), 32'(d), 32'((k == 0) ? last0 : last1));
            if (sz != 0) begin
                e = (k == 0) ? q0[0] : q1[0];
                if (e.cyc <= cyc) begin
                    fail("missing_dob_valid", k);
                    if (k == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n === 1'b1) mon(0, if0.dob_valid, if0.dob);
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n === 1'b1) mon(1, if1.dob_valid, if1.dob);
    end

    task automatic set_in(input logic ea, input logic [1:0] w, input logic [9:0] aa,
                          input logic [15:0] d, input logic eb, input logic [9:0] ab);
        if0.ena = ea; if0.wea = w; if0.addra = aa; if0.dia = d; if0.enb = eb; if0.addrb = ab;
        if1.ena = ea; if1.wea = w; if1.addra = aa; if1.dia = d; if1.enb = eb; if1.addrb = ab;
    endtask

    // Called at a negedge: applies one cycle of requests and predicts its effect.
    task automatic drive(input logic ea, input logic [1:0] w, input logic [9:0] aa,
                         input logic [15:0] d, input logic eb, input logic [9:0] ab);
        logic [15:0] old_w, new_w;
        exp_t        e;
        chk("init_busy0", 32'(if0.init_busy), 32'(busy_left > 0));
        chk("init_busy1", 32'(if1.init_busy), 32'(busy_left > 0));
        set_in(ea, w, aa, d, eb, ab);
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (eb) begin
                old_w = (int'(ab) < DEP) ? mdl[ab] : 16'h0000;
                new_w = old_w;
                if (ea && aa == ab && int'(aa) < DEP) begin
                    for (int i = 0; i < 2; i++) if (w[i]) new_w[8*i +: 8] = d[8*i +: 8];
                end
                e.data = old_w; e.cyc = cyc + 1; q0.push_back(e);
                e.data = new_w; e.cyc = cyc + 2; q1.push_back(e);
            end
            if (ea && int'(aa) < DEP) begin
                for (int i = 0; i < 2; i++) if (w[i]) mdl[aa][8*i +: 8] = d[8*i +: 8];
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b0, 10'd0);
    endtask

    function automatic logic [9:0] raddr();
        if ($urandom_range(0, 7) == 0) return 10'($urandom_range(995, 1023));
        return 10'($urandom_range(0, 15));
    endfunction

    task automatic rnd(input int n);
        repeat (n) drive(1'($urandom), 2'($urandom), raddr(), 16'($urandom), 1'($urandom), raddr());
    endtask

    // Called at a negedge: holds reset n cycles, then the model expects a full sweep.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        set_in(1'b0, 2'b00, 10'd0, 16'h0, 1'b0, 10'd0);
        #1;
        q0.delete();
        q1.delete();
        last0 = 16'h0;
        last1 = 16'h0;
        chk("rst_dob0", 32'(if0.dob), 32'h0);
        chk("rst_dob1", 32'(if1.dob), 32'h0);
        chk("rst_valid0", 32'(if0.dob_valid), 32'h0);
        chk("rst_valid1", 32'(if1.dob_valid), 32'h0);
        chk("rst_busy0", 32'(if0.init_busy), 32'h1);
        chk("rst_busy1", 32'(if1.init_busy), 32'h1);
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEP; i++) mdl[i] = INIT;
        busy_left = DEP;
    endtask

    initial begin
        rst_n = 1'b0;
        last0 = 16'h0;
        last1 = 16'h0;
        set_in(1'b0, 2'b00, 10'd0, 16'h0, 1'b0, 10'd0);
        repeat (2) @(negedge clk);
        do_reset(2);

        // Sweep with random requests that must be ignored
        while (busy_left > 0) rnd(1);

        drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd0);
        drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd511);
        drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd999);
        idle(3);

        // Byte-lane merge
        drive(1'b1, 2'b11, 10'd5, 16'h1234, 1'b0, 10'd0);
        drive(1'b1, 2'b10, 10'd5, 16'hAB00, 1'b0, 10'd0);
        drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd5);
        idle(3);

        // Read-during-write on the same address
        drive(1'b1, 2'b11, 10'd7, 16'h0000, 1'b0, 10'd0);
        drive(1'b1, 2'b01, 10'd7, 16'hBEEF, 1'b1, 10'd7);
        drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd7);
        idle(3);

        // Burst read
        for (int i = 0; i < 8; i++) drive(1'b1, 2'b11, 10'(i), 16'(i), 1'b0, 10'd0);
        for (int i = 0; i < 8; i++) drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'(i));
        idle(3);

        // Out-of-range write dropped, out-of-range read returns zero
        drive(1'b1, 2'b11, 10'd1010, 16'hDEAD, 1'b0, 10'd0);
        drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd1010);
        drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd10);
        idle(3);

        rnd(400);

        // Reads in flight when reset hits are discarded
        drive(1'b1, 2'b11, 10'd3, 16'h7777, 1'b1, 10'd3);
        drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd4);
        do_reset(2);

        repeat (300) rnd(1);
        do_reset(2);
        while (busy_left > 0) rnd(1);

        drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd5);
        drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd7);
        drive(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd3);
        rnd(200);
        idle(5);

        chk("drain0", 32'(q0.size()), 32'h0);
        chk("drain1", 32'(q1.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
